// File: rtl/wb_pkg.sv
// Shared write-back definitions: source select encoding and datapath sizing
// used by decode, the put-constant lookup stage and the register file.
package wb_pkg;

  localparam int REG_W    = 8;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_PUT  = 2'd1,
    WB_MEM  = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_t;

endpackage

// File: rtl/put_wb_regfile.sv
// Write-back stage and register file: source mux, one pipeline register,
// register array, two forwarding read ports, PUT counter and illegal flag.
module put_wb_regfile
  import wb_pkg::*;
#(
  parameter int REG_W    = wb_pkg::REG_W,
  parameter int NUM_REGS = wb_pkg::NUM_REGS,
  parameter int ADDR_W   = wb_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              stall,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_sel,
  input  logic [REG_W-1:0]  alu_result,
  input  logic [REG_W-1:0]  put_data,
  input  logic [REG_W-1:0]  mem_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [REG_W-1:0]  rd_data_a,
  output logic [REG_W-1:0]  rd_data_b,
  output logic              wb_pending,
  output logic [7:0]        put_count,
  output logic              illegal_sel
);

  logic [REG_W-1:0]  regs_q [NUM_REGS];
  logic [REG_W-1:0]  regs_d [NUM_REGS];
  logic              pipe_v_q, pipe_v_d;
  logic [ADDR_W-1:0] pipe_addr_q, pipe_addr_d;
  logic [REG_W-1:0]  pipe_data_q, pipe_data_d;
  logic [7:0]        put_count_q, put_count_d;
  logic              illegal_q, illegal_d;

  wb_sel_t          sel;
  logic             src_valid;
  logic [REG_W-1:0] src_data;
  logic             accept;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  // The pending entry shadows the array; unmapped addresses read as zero.
  function automatic logic [REG_W-1:0] fwd_read(
    input logic              pv,
    input logic [ADDR_W-1:0] pa,
    input logic [REG_W-1:0]  pd,
    input logic [ADDR_W-1:0] ra,
    input logic [REG_W-1:0]  arr_val
  );
    if (pv && (ra == pa)) return pd;
    if (addr_ok(ra))      return arr_val;
    return '0;
  endfunction

  assign sel    = wb_sel_t'(wr_sel);
  assign accept = !stall;

  always_comb begin
    src_valid = 1'b1;
    src_data  = '0;
    case (sel)
      WB_ALU:  src_data = alu_result;
      WB_PUT:  src_data = put_data;
      WB_MEM:  src_data = mem_data;
      default: src_valid = 1'b0;
    endcase
  end

  always_comb begin
    regs_d      = regs_q;
    pipe_v_d    = pipe_v_q;
    pipe_addr_d = pipe_addr_q;
    pipe_data_d = pipe_data_q;
    put_count_d = put_count_q;
    illegal_d   = illegal_q;

    if (pipe_v_q && addr_ok(pipe_addr_q)) begin
      regs_d[pipe_addr_q] = pipe_data_q;
    end

    if (accept) begin
      pipe_v_d    = wr_en && src_valid && addr_ok(wr_addr);
      pipe_addr_d = wr_addr;
      pipe_data_d = src_data;
      if (wr_en && (sel == WB_PUT) && (put_count_q != 8'hFF)) begin
        put_count_d = put_count_q + 8'd1;
      end
      if (wr_en && (sel == WB_RSVD)) begin
        illegal_d = 1'b1;
      end
    end else begin
      // Bubble: the held request is re-presented once stall drops.
      pipe_v_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pipe_v_q    <= 1'b0;
      pipe_addr_q <= '0;
      pipe_data_q <= '0;
      put_count_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      pipe_v_q    <= pipe_v_d;
      pipe_addr_q <= pipe_addr_d;
      pipe_data_q <= pipe_data_d;
      put_count_q <= put_count_d;
      illegal_q   <= illegal_d;
    end
  end

  assign rd_data_a   = fwd_read(pipe_v_q, pipe_addr_q, pipe_data_q, rd_addr_a, regs_q[rd_addr_a]);
  assign rd_data_b   = fwd_read(pipe_v_q, pipe_addr_q, pipe_data_q, rd_addr_b, regs_q[rd_addr_b]);
  assign wb_pending  = pipe_v_q;
  assign put_count   = put_count_q;
  assign illegal_sel = illegal_q;

endmodule

// File: tb/tb_put_wb_regfile.sv
// Self-checking bench for put_wb_regfile: directed scenarios plus random
// traffic against an architectural model where an accepted write is visible at once.
module tb_put_wb_regfile;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       stall = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [1:0] wr_sel = '0;
  logic [7:0] alu_result = '0;
  logic [7:0] put_data = '0;
  logic [7:0] mem_data = '0;
  logic [2:0] rd_addr_a = '0;
  logic [2:0] rd_addr_b = '0;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic       wb_pending;
  logic [7:0] put_count;
  logic       illegal_sel;

  put_wb_regfile dut (
    .Clk(Clk), .Reset(Reset), .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_sel(wr_sel), .alu_result(alu_result), .put_data(put_data), .mem_data(mem_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b), .wb_pending(wb_pending), .put_count(put_count),
    .illegal_sel(illegal_sel)
  );

  always #5 Clk = ~Clk;

  // Reference: architectural view (newest accepted value per register).
  logic [7:0] m_regs [8];
  logic       m_pend;
  int         m_cnt;
  logic       m_ill;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_pend = 1'b0;
    m_cnt  = 0;
    m_ill  = 1'b0;
  endtask

  // Drive one request, clock it, update the model, settle 1 time unit past the edge.
  task automatic cyc(input logic en, input logic [1:0] sel, input logic [2:0] addr,
                     input logic [7:0] alu, input logic [7:0] put, input logic [7:0] mem,
                     input logic stl);
    logic [7:0] v;
    wr_en = en; wr_sel = sel; wr_addr = addr;
    alu_result = alu; put_data = put; mem_data = mem; stall = stl;
    @(posedge Clk);
    if (!stl) begin
      v = (sel == 2'd0) ? alu : (sel == 2'd1) ? put : mem;
      m_pend = en && (sel != 2'd3);
      if (m_pend) m_regs[addr] = v;
      if (en && sel == 2'd1 && m_cnt < 255) m_cnt++;
      if (en && sel == 2'd3) m_ill = 1'b1;
    end else begin
      m_pend = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_pending"}, {31'd0, wb_pending}, {31'd0, m_pend});
    chk({tag, "_count"}, {24'd0, put_count}, m_cnt);
    chk({tag, "_illegal"}, {31'd0, illegal_sel}, {31'd0, m_ill});
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [2:0] b);
    rd_addr_a = a; rd_addr_b = b;
    #1;
    chk({tag, "_rd_a"}, {24'd0, rd_data_a}, {24'd0, m_regs[a]});
    chk({tag, "_rd_b"}, {24'd0, rd_data_b}, {24'd0, m_regs[b]});
  endtask

  task automatic chk_all(input string tag);
    chk_status(tag);
    for (int i = 0; i < 8; i++) chk_reg(tag, 3'(i), 3'(7 - i));
  endtask

  initial begin
    model_reset();
    Reset = 1'b1;
    #12;
    Reset = 1'b0;
    @(negedge Clk);
    chk_all("por");

    // PUT write to r3, forwarded then committed.
    cyc(1'b1, 2'd1, 3'd3, 8'h00, 8'h0E, 8'h00, 1'b0);
    chk_reg("put_fwd", 3'd3, 3'd3);
    chk("put_fwd_const", {24'd0, rd_data_a}, 32'h0E);
    chk_status("put_fwd");
    chk("put_fwd_pend_const", {31'd0, wb_pending}, 32'd1);
    idle();
    chk_reg("put_commit", 3'd3, 3'd0);
    chk("put_commit_const", {24'd0, rd_data_a}, 32'h0E);
    chk("put_commit_pend_const", {31'd0, wb_pending}, 32'd0);
    chk("put_count_one", {24'd0, put_count}, 32'd1);

    // Back-to-back ALU then MEM to r5.
    cyc(1'b1, 2'd0, 3'd5, 8'h10, 8'h00, 8'h00, 1'b0);
    chk_reg("b2b_first", 3'd0, 3'd5);
    cyc(1'b1, 2'd2, 3'd5, 8'h00, 8'h00, 8'hFF, 1'b0);
    chk_reg("b2b_second", 3'd0, 3'd5);
    chk("b2b_second_const", {24'd0, rd_data_b}, 32'hFF);
    idle();
    idle();
    chk_all("b2b_drain");

    // Stall bubble on r2.
    cyc(1'b1, 2'd0, 3'd2, 8'h80, 8'h00, 8'h00, 1'b0);
    cyc(1'b1, 2'd0, 3'd2, 8'h01, 8'h00, 8'h00, 1'b1);
    chk_reg("stall1", 3'd2, 3'd2);
    chk("stall1_const", {24'd0, rd_data_a}, 32'h80);
    chk("stall1_pend_const", {31'd0, wb_pending}, 32'd0);
    cyc(1'b1, 2'd0, 3'd2, 8'h01, 8'h00, 8'h00, 1'b1);
    chk_reg("stall2", 3'd2, 3'd2);
    cyc(1'b1, 2'd0, 3'd2, 8'h01, 8'h00, 8'h00, 1'b0);
    chk_reg("stall_rel", 3'd2, 3'd2);
    chk("stall_rel_const", {24'd0, rd_data_a}, 32'h01);
    idle();
    chk_all("stall_drain");

    // Reserved select to r1.
    cyc(1'b1, 2'd3, 3'd1, 8'hAA, 8'hBB, 8'hCC, 1'b0);
    chk_all("rsvd");
    chk("rsvd_flag_const", {31'd0, illegal_sel}, 32'd1);
    idle();
    idle();
    chk_status("rsvd_sticky");

    // 260 consecutive PUT writes saturate the counter.
    for (int i = 0; i < 260; i++) begin
      cyc(1'b1, 2'd1, 3'(i), 8'h00, 8'(i * 7), 8'h00, 1'b0);
      if (m_cnt >= 254) chk_status("sat_walk");
    end
    idle();
    chk("sat_const", {24'd0, put_count}, 32'd255);
    chk_all("sat");

    // Random traffic with occasional stalls.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom),
          8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 4) == 0));
      chk_status("rnd");
      chk_reg("rnd", 3'($urandom), 3'($urandom));
    end

    // Reset asserted mid-cycle with a write pending.
    cyc(1'b1, 2'd0, 3'd6, 8'h5A, 8'h00, 8'h00, 1'b0);
    chk("prereset_pend", {31'd0, wb_pending}, 32'd1);
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    chk_all("mid_reset");
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    wr_en = 1'b0;
    @(negedge Clk);
    chk_all("post_reset");
    idle();
    chk_all("post_reset_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/put_wb_regfile.md
Name: put_wb_regfile

Overview:
- Write-back stage plus register file that consumes the 8-bit constant produced by the put-constant lookup stage. It also consumes ALU results and memory load data.
- One pipeline register sits between the write-back source mux and the register array.
- Two combinational read ports, with forwarding from the pending write-back entry.
- Also keeps a saturating count of PUT write-backs and a sticky illegal-select flag for the testbench and debug.

Parameters:
- REG_W, 8, data width of each register and of every write source
- NUM_REGS, 8, number of architectural registers
- ADDR_W, 3, register address width; must equal clog2(NUM_REGS)

Ports:
- Clk  input  1  single clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-high; clears all state immediately
- stall  input  1  when 1, a new write-back request is not accepted and a bubble is inserted
- wr_en  input  1  write-back request valid this cycle
- wr_addr  input  ADDR_W  destination register
- wr_sel  input  2  source select: 0=ALU, 1=PUT, 2=MEM, 3=reserved
- alu_result  input  REG_W  ALU output
- put_data  input  REG_W  constant from the put-constant lookup stage
- mem_data  input  REG_W  data memory read value
- rd_addr_a  input  ADDR_W  read port A address
- rd_addr_b  input  ADDR_W  read port B address
- rd_data_a  output  REG_W  read port A data
- rd_data_b  output  REG_W  read port B data
- wb_pending  output  1  pipeline register holds a valid uncommitted write
- put_count  output  8  saturating count of accepted PUT write-backs
- illegal_sel  output  1  sticky; set when wr_en=1 with wr_sel=3 is accepted

Behaviour:
- Reset (async, any time, including mid-operation): all NUM_REGS registers=0, pipe_v=0, pipe_addr=0, pipe_data=0, put_count=0, illegal_sel=0. Outputs read 0 during and after reset until the first commit. A request pending at reset assertion is discarded.
- Source mux (combinational):
  - wr_sel 0 -> alu_result
  - wr_sel 1 -> put_data
  - wr_sel 2 -> mem_data
  - wr_sel 3 -> no write
- Each rising edge (Reset=0), in this order of effect:
  1. Commit: if pipe_v=1, then array[pipe_addr] <= pipe_data.
  2. Accept: if stall=0, then:
     - pipe_v <= wr_en and (wr_sel != 3)
     - pipe_addr <= wr_addr
     - pipe_data <= mux output
  3. Stall: if stall=1, then pipe_v <= 0 (bubble); pipe_addr and pipe_data hold.
     - The input request is not accepted. Upstream must hold it stable while stall=1.
- Latency: a request accepted at edge N is visible via forwarding from N until N+1. It is in the array from edge N+1 onward.
- Read ports (combinational), evaluated independently for A and B:
  - if pipe_v=1 and rd_addr==pipe_addr -> pipe_data
  - else -> array[rd_addr]
  - No forwarding from the same-cycle, not-yet-accepted input. Two consecutive writes to the same address: reads see the newest pending value.
- Back-to-back writes to the same address: the older value commits at the same edge the newer one enters the pipe. No loss occurs; the final array value is the newer one.
- put_count: increments by 1 on each accepted request with wr_en=1 and wr_sel=1. Saturates at 255 and never wraps.
- illegal_sel: set to 1 on an accepted request with wr_en=1 and wr_sel=3. Cleared only by Reset. No register is written.
- wb_pending = pipe_v.
- wr_addr >= NUM_REGS (only possible if the parameters are changed): the write is dropped, and reads of that address return 0.

Decomposition:
- Package wb_pkg holds:
  - typedef enum logic[1:0] wb_sel_t {WB_ALU=0, WB_PUT=1, WB_MEM=2, WB_RSVD=3}
  - localparams REG_W, NUM_REGS, ADDR_W for shared use with decode and the put-constant lookup stage
- No sub-module is needed. The source mux, pipeline register, array and forwarding all live in one module. The read-port forwarding logic may be a function reused for both ports.

Test Plan:
- Reset then idle: assert Reset mid-cycle with pipe_v=1 -> wb_pending=0 immediately; rd_data_a/b=0 for all addresses; put_count=0.
- PUT write, forward then commit:
  - Stimulus: wr_en=1, wr_sel=1, wr_addr=3, put_data=8'h0E, then wr_en=0.
  - Cycle after accept: rd_addr_a=3 -> 8'h0E via forward, wb_pending=1.
  - Next cycle: wb_pending=0, still 8'h0E; put_count=1.
- Back-to-back same address:
  - Stimulus: ALU write r5=8'h10, then MEM write r5=8'hFF in consecutive cycles.
  - After the second accept: rd_data_b(5)=8'hFF; after drain, r5=8'hFF.
- Stall bubble:
  - Stimulus: write r2=8'h80 accepted, then stall=1 for 2 cycles with wr_en=1, wr_addr=2, wr_sel=0, alu_result=8'h01.
  - During the stall: r2 reads 8'h80 and wb_pending=0 after the first stall edge.
  - Release stall -> r2=8'h01 one cycle later.
- Reserved select: wr_en=1, wr_sel=3, wr_addr=1 -> illegal_sel=1 (sticky), r1 unchanged, wb_pending=0.
- Saturation: 260 consecutive PUT writes -> put_count=255 and holds.
